// File: rtl/reaction_game_pkg.sv
// Shared encodings for the reaction game engine: FSM states, result codes
// and the Galois LFSR tap masks for counter widths 8-16.
package reaction_game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_WAIT      = 3'd2,
        ST_GO        = 3'd3,
        ST_RESULT    = 3'd4,
        ST_FINAL     = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        RES_NONE        = 2'd0,
        RES_HIT         = 2'd1,
        RES_FALSE_START = 2'd2,
        RES_TIMEOUT     = 2'd3
    } result_t;

    // Right-shift Galois masks; bit k-1 set for each x^k term (x^0 implied).
    function automatic logic [15:0] lfsr_taps(input int w);
        case (w)
            8:       return 16'h00B8;  // x^8+x^6+x^5+x^4+1
            9:       return 16'h0110;  // x^9+x^5+1
            10:      return 16'h0240;  // x^10+x^7+1
            11:      return 16'h0500;  // x^11+x^9+1
            12:      return 16'h0829;  // x^12+x^6+x^4+x+1
            13:      return 16'h100D;  // x^13+x^4+x^3+x+1
            14:      return 16'h2015;  // x^14+x^5+x^3+x+1
            15:      return 16'h6000;  // x^15+x^14+1
            16:      return 16'hD008;  // x^16+x^15+x^13+x^4+1
            default: return 16'h0110;
        endcase
    endfunction

endpackage

// File: rtl/reaction_game_core_lfsr.sv
// Parametric Galois LFSR used to randomise the wait delay; a zero seed is
// replaced by 1 so the register can never lock up in the all-zero state.
module lfsr_gen
    import reaction_game_pkg::*;
#(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         step,
    input  logic [W-1:0] seed,
    output logic [W-1:0] value
);

    localparam logic [W-1:0] TAPS = W'(lfsr_taps(W));

    always_ff @(posedge clk) begin
        if (rst)
            value <= W'(1);
        else if (load)
            value <= (seed == '0) ? W'(1) : seed;
        else if (step)
            value <= value[0] ? ((value >> 1) ^ TAPS) : (value >> 1);
    end

endmodule

// File: rtl/reaction_game_core.sv
// Multi-round, multi-player reaction game: countdown, random wait, go window,
// first-press arbitration and per-player saturating scores.
module reaction_game_core
    import reaction_game_pkg::*;
#(
    parameter int PLAYERS   = 2,
    parameter int ROUNDS    = 4,
    parameter int CNT_W     = 9,
    parameter int DELAY_MIN = 100,
    parameter int TIMEOUT   = 300,
    parameter int COUNTDOWN = 5,
    localparam int WIN_W    = (PLAYERS > 1) ? $clog2(PLAYERS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick_100hz,
    input  logic                 tick_1hz,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CNT_W-1:0]     seed,
    input  logic [PLAYERS-1:0]   btn,
    output logic [2:0]           state,
    output logic                 go,
    output logic [2:0]           countdown,
    output logic [3:0]           round,
    output logic [1:0]           result,
    output logic                 result_valid,
    output logic [WIN_W-1:0]     winner,
    output logic [CNT_W-1:0]     react_time,
    output logic [4*PLAYERS-1:0] score,
    output logic                 done
);

    localparam logic [CNT_W-1:0] DMIN = CNT_W'(DELAY_MIN);
    localparam logic [CNT_W-1:0] TMO  = CNT_W'(TIMEOUT);
    localparam logic [3:0]       LAST = 4'(ROUNDS - 1);

    state_t                      state_q, state_d;
    result_t                     result_q;
    logic [PLAYERS-1:0]          btn_q, edge_v;
    logic [PLAYERS-1:0][3:0]     score_q;
    logic [WIN_W-1:0]            first;
    logic [CNT_W-1:0]            delay_q, react_q, lfsr_val, load_val;
    logic                        any_edge;
    logic                        do_start, do_load, ev_fs, ev_hit, ev_tmo, next_round;

    lfsr_gen #(.W(CNT_W)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (do_start),
        .step  (do_load),
        .seed  (seed),
        .value (lfsr_val)
    );

    always_ff @(posedge clk) btn_q <= btn;

    assign edge_v   = btn & ~btn_q;
    assign any_edge = |edge_v;
    assign load_val = (lfsr_val < DMIN) ? lfsr_val + DMIN : lfsr_val;

    // Lowest-index player wins when several press in the same cycle.
    always_comb begin
        first = '0;
        for (int p = PLAYERS - 1; p >= 0; p--)
            if (edge_v[p]) first = WIN_W'(p);
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        do_start   = 1'b0;
        do_load    = 1'b0;
        ev_fs      = 1'b0;
        ev_hit     = 1'b0;
        ev_tmo     = 1'b0;
        next_round = 1'b0;
        case (state_q)
            ST_IDLE, ST_FINAL:
                if (start) begin
                    do_start = 1'b1;
                    state_d  = ST_COUNTDOWN;
                end
            ST_COUNTDOWN:
                if (tick_1hz && countdown == 3'd1) begin
                    do_load = 1'b1;
                    state_d = ST_WAIT;
                end
            ST_WAIT:
                if (any_edge) begin
                    ev_fs   = 1'b1;
                    state_d = ST_RESULT;
                end else if (delay_q == '0) begin
                    state_d = ST_GO;
                end
            ST_GO:
                if (any_edge) begin
                    ev_hit  = 1'b1;
                    state_d = ST_RESULT;
                end else if (react_q == TMO) begin
                    ev_tmo  = 1'b1;
                    state_d = ST_RESULT;
                end
            ST_RESULT:
                if (tick_1hz) begin
                    if (round == LAST) begin
                        state_d = ST_FINAL;
                    end else begin
                        next_round = 1'b1;
                        do_load    = 1'b1;
                        state_d    = ST_WAIT;
                    end
                end
            default: state_d = ST_IDLE;
        endcase
        // Abort wins over every event in the same cycle.
        if (abort) begin
            state_d    = ST_IDLE;
            do_start   = 1'b0;
            do_load    = 1'b0;
            ev_fs      = 1'b0;
            ev_hit     = 1'b0;
            ev_tmo     = 1'b0;
            next_round = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            countdown    <= '0;
            round        <= '0;
            result_q     <= RES_NONE;
            result_valid <= 1'b0;
            winner       <= '0;
            react_time   <= '0;
            score_q      <= '0;
            delay_q      <= '0;
            react_q      <= '0;
        end else if (abort) begin
            countdown    <= '0;
            round        <= '0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= (state_d == ST_RESULT) && (state_q != ST_RESULT);
            if (do_start) begin
                score_q   <= '0;
                round     <= '0;
                result_q  <= RES_NONE;
                countdown <= 3'(COUNTDOWN);
            end
            if (state_q == ST_COUNTDOWN && tick_1hz && countdown != '0)
                countdown <= countdown - 3'd1;
            if (do_load)
                delay_q <= load_val;
            else if (state_q == ST_WAIT && !any_edge && tick_100hz && delay_q != '0)
                delay_q <= delay_q - 1'b1;
            if (state_q == ST_WAIT && state_d == ST_GO)
                react_q <= '0;
            else if (state_q == ST_GO && !any_edge && tick_100hz && react_q != TMO)
                react_q <= react_q + 1'b1;
            if (ev_fs) begin
                result_q <= RES_FALSE_START;
                winner   <= first;
                if (score_q[first] != 4'd0) score_q[first] <= score_q[first] - 4'd1;
            end
            if (ev_hit) begin
                result_q   <= RES_HIT;
                winner     <= first;
                react_time <= react_q;
                if (score_q[first] != 4'hF) score_q[first] <= score_q[first] + 4'd1;
            end
            if (ev_tmo)
                result_q <= RES_TIMEOUT;
            if (next_round) begin
                round    <= round + 4'd1;
                result_q <= RES_NONE;
            end
        end
    end

    assign state  = state_q;
    assign result = result_q;
    assign score  = score_q;
    assign go     = (state_q == ST_GO);
    assign done   = (state_q == ST_FINAL);

endmodule

// File: tb/tb_reaction_game_core.sv
// Directed-plus-random bench for reaction_game_core (ROUNDS=2) against a
// game-level reference model of scores, results and delays.
module tb_reaction_game_core;

    localparam int P = 2, R = 2, W = 9, DMIN = 100, TMO = 300, CD = 5;
    localparam int S_IDLE = 0, S_CD = 1, S_WAIT = 2, S_GO = 3, S_RES = 4, S_FIN = 5;
    localparam int R_NONE = 0, R_HIT = 1, R_FS = 2, R_TMO = 3;

    logic           clk = 1'b0;
    logic           rst, tick_100hz, tick_1hz, start, abort;
    logic [W-1:0]   seed;
    logic [P-1:0]   btn;
    logic [2:0]     state, countdown;
    logic           go, result_valid, done;
    logic [3:0]     round;
    logic [1:0]     result;
    logic [0:0]     winner;
    logic [W-1:0]   react_time;
    logic [4*P-1:0] score;

    int n_chk = 0, n_fail = 0;
    int exp_score[P];
    int exp_round, exp_result, exp_winner, exp_react;

    always #5 clk = ~clk;

    reaction_game_core #(
        .PLAYERS(P), .ROUNDS(R), .CNT_W(W), .DELAY_MIN(DMIN), .TIMEOUT(TMO), .COUNTDOWN(CD)
    ) dut (
        .clk(clk), .rst(rst), .tick_100hz(tick_100hz), .tick_1hz(tick_1hz),
        .start(start), .abort(abort), .seed(seed), .btn(btn),
        .state(state), .go(go), .countdown(countdown), .round(round),
        .result(result), .result_valid(result_valid), .winner(winner),
        .react_time(react_time), .score(score), .done(done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] score_word();
        logic [31:0] w = 0;
        for (int p = 0; p < P; p++) w = w + (32'(exp_score[p]) << (4 * p));
        return w;
    endfunction

    function automatic int exp_delay(input int s);
        int v = (s == 0) ? 1 : s;
        return (v < DMIN) ? v + DMIN : v;
    endfunction

    // Game-level model of the scoring rules.
    task automatic m_reset();
        for (int p = 0; p < P; p++) exp_score[p] = 0;
        exp_round = 0; exp_result = R_NONE; exp_winner = 0; exp_react = 0;
    endtask
    task automatic m_start();
        for (int p = 0; p < P; p++) exp_score[p] = 0;
        exp_round = 0; exp_result = R_NONE;
    endtask
    task automatic m_hit(input int p, input int t);
        exp_result = R_HIT; exp_winner = p; exp_react = t;
        exp_score[p] = (exp_score[p] >= 15) ? 15 : exp_score[p] + 1;
    endtask
    task automatic m_fs(input int p);
        exp_result = R_FS; exp_winner = p;
        exp_score[p] = (exp_score[p] <= 0) ? 0 : exp_score[p] - 1;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic tick100();
        tick_100hz = 1'b1; cyc(); tick_100hz = 1'b0;
    endtask
    task automatic tick1();
        tick_1hz = 1'b1; cyc(); tick_1hz = 1'b0;
    endtask
    task automatic press(input logic [P-1:0] m);
        btn = m; cyc(); btn = '0;
    endtask
    task automatic do_start(input logic [W-1:0] s);
        seed = s; start = 1'b1; cyc(); start = 1'b0; seed = '0;
        m_start();
    endtask

    task automatic check_outs(input string tag, input int exp_state);
        chk({tag, "/state"},  32'(state), exp_state);
        chk({tag, "/result"}, 32'(result), exp_result);
        chk({tag, "/winner"}, 32'(winner), exp_winner);
        chk({tag, "/react"},  32'(react_time), exp_react);
        chk({tag, "/score"},  32'(score), score_word());
        chk({tag, "/round"},  32'(round), exp_round);
    endtask

    task automatic run_countdown();
        for (int i = 1; i <= CD; i++) begin
            tick1();
            chk("countdown", 32'(countdown), CD - i);
        end
        chk("cd_to_wait", 32'(state), S_WAIT);
    endtask

    // Counts 100 Hz ticks spent in WAIT before GO, bounded.
    task automatic wait_go(output int n);
        bit ok = 0;
        n = 0;
        for (int i = 0; i < 600; i++) begin
            cyc();
            if (go) begin ok = 1; break; end
            tick100();
            n++;
        end
        chk("go_reached", 32'(ok), 1);
    endtask

    task automatic check_reset(input string tag);
        m_reset();
        check_outs(tag, S_IDLE);
        chk({tag, "/go"}, 32'(go), 0);
        chk({tag, "/done"}, 32'(done), 0);
        chk({tag, "/rv"}, 32'(result_valid), 0);
        chk({tag, "/cd"}, 32'(countdown), 0);
    endtask

    initial begin
        int n, k, d, p;
        logic [W-1:0] s;
        rst = 1'b1; tick_100hz = 1'b0; tick_1hz = 1'b0; start = 1'b0;
        abort = 1'b0; seed = '0; btn = '0;
        m_reset();
        repeat (3) cyc();
        check_reset("reset");
        rst = 1'b0;
        cyc();

        // Round 0: seed 0x1A5 gives a first delay of 421; player 1 hits at 40.
        do_start(9'h1A5);
        chk("start/state", 32'(state), S_CD);
        chk("start/cd", 32'(countdown), CD);
        start = 1'b1; cyc(); start = 1'b0;
        chk("start_ignored/state", 32'(state), S_CD);
        chk("start_ignored/cd", 32'(countdown), CD);
        run_countdown();
        wait_go(n);
        chk("delay_seed", 32'(n), exp_delay(9'h1A5));
        repeat (40) tick100();
        press(2'b10);
        m_hit(1, 40);
        check_outs("hit40", S_RES);
        chk("hit40/rv", 32'(result_valid), 1);
        cyc();
        chk("hit40/rv_pulse", 32'(result_valid), 0);
        chk("hit40/held", 32'(result), R_HIT);

        // Round 1: false start by player 0 at score 0 saturates.
        tick1();
        exp_round = 1; exp_result = R_NONE;
        check_outs("round1", S_WAIT);
        k = $urandom_range(1, 50);
        repeat (k) tick100();
        press(2'b01);
        m_fs(0);
        check_outs("fs_sat", S_RES);
        tick1();
        check_outs("final1", S_FIN);
        chk("final1/done", 32'(done), 1);

        // Restart from FINAL with seed 0, then let the go window time out.
        do_start('0);
        check_outs("restart", S_CD);
        chk("restart/cd", 32'(countdown), CD);
        run_countdown();
        wait_go(n);
        chk("delay_seed0", 32'(n), exp_delay(0));
        repeat (TMO) tick100();
        chk("at_timeout/state", 32'(state), S_GO);
        cyc();
        exp_result = R_TMO;
        check_outs("timeout", S_RES);
        chk("timeout/rv", 32'(result_valid), 1);

        // Simultaneous presses plus tick: player 0 wins with pre-increment count.
        tick1();
        exp_round = 1; exp_result = R_NONE;
        wait_go(n);
        chk("delay_range", 32'(n >= DMIN && n < (1 << W)), 1);
        k = $urandom_range(1, 60);
        repeat (k) tick100();
        btn = 2'b11; tick_100hz = 1'b1; cyc(); btn = '0; tick_100hz = 1'b0;
        m_hit(0, k);
        check_outs("dual", S_RES);
        tick1();
        chk("final2/done", 32'(done), 1);

        // Random seed: press exactly when the delay reaches zero.
        s = W'($urandom_range(0, (1 << W) - 1));
        d = exp_delay(int'(s));
        do_start(s);
        run_countdown();
        repeat (d) tick100();
        chk("delay0/state", 32'(state), S_WAIT);
        p = $urandom_range(0, P - 1);
        press(P'(1 << p));
        m_fs(p);
        check_outs("fs_at_zero", S_RES);

        // Button held into WAIT makes no press; then press exactly at TIMEOUT.
        btn = 2'b10; cyc();
        tick1();
        exp_round = 1; exp_result = R_NONE;
        wait_go(n);
        btn = '0;
        repeat (TMO) tick100();
        press(2'b10);
        m_hit(1, TMO);
        check_outs("hit_at_tmo", S_RES);
        tick1();
        chk("final3/done", 32'(done), 1);

        // Abort during GO keeps scores and result, clears round.
        s = W'($urandom_range(0, (1 << W) - 1));
        do_start(s);
        run_countdown();
        wait_go(n);
        chk("delay_rand", 32'(n), exp_delay(int'(s)));
        k = $urandom_range(0, 80);
        repeat (k) tick100();
        p = $urandom_range(0, P - 1);
        press(P'(1 << p));
        m_hit(p, k);
        check_outs("hit_rand", S_RES);
        tick1();
        exp_round = 1; exp_result = R_NONE;
        wait_go(n);
        repeat (5) tick100();
        abort = 1'b1; cyc(); abort = 1'b0;
        exp_round = 0;
        check_outs("abort", S_IDLE);
        chk("abort/go", 32'(go), 0);

        // Reset together with abort and a button edge restores reset values.
        rst = 1'b1; abort = 1'b1; btn = 2'b01;
        cyc();
        rst = 1'b0; abort = 1'b0; btn = '0;
        check_reset("rst_mid");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
